// File: rtl/datapath_sequencer_if.sv
// Instruction handshake and register-file/ALU control bundle.
// Ports: instr_valid/instr/instr_ready handshake; A/B/D addresses, ReadOrWrite, FS, done, instr_count.
interface datapath_sequencer_if;
   logic        instr_valid;
   logic [11:0] instr;
   logic        instr_ready;
   logic [2:0]  AAddress;
   logic [2:0]  BAddress;
   logic [2:0]  DAddress;
   logic        ReadOrWrite;
   logic [2:0]  FS;
   logic        done;
   logic [7:0]  instr_count;

   modport master (
      output instr_valid,
      output instr,
      input  instr_ready,
      input  AAddress,
      input  BAddress,
      input  DAddress,
      input  ReadOrWrite,
      input  FS,
      input  done,
      input  instr_count
   );

   modport slave (
      input  instr_valid,
      input  instr,
      output instr_ready,
      output AAddress,
      output BAddress,
      output DAddress,
      output ReadOrWrite,
      output FS,
      output done,
      output instr_count
   );
endinterface

// File: rtl/datapath_sequencer.sv
// Sequences one 12-bit instruction into register-file read/write and ALU select cycles.
// Ports: clk, rst (sync, active high), bus (slave side of datapath_sequencer_if).
module datapath_sequencer (
   input logic           clk,
   input logic           rst,
   datapath_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      CLEAR
   } state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_CLRALL = 3'b111;
   localparam logic [2:0] FS_ZERO = 3'b101;

   state_t      state_q;
   logic [2:0]  op_q;
   logic [2:0]  da_q;
   logic [2:0]  clr_q;
   logic [2:0]  a_q;
   logic [2:0]  b_q;
   logic [2:0]  d_q;
   logic [2:0]  fs_q;
   logic        rw_q;
   logic        done_q;
   logic [7:0]  icnt_q;

   logic [2:0]  op_in;
   logic [2:0]  fs_in;

   assign op_in = bus.instr[11:9];

   // MOV passes A through (FS 000); CLR/CLRALL force zero (FS 101).
   always_comb begin
      fs_in = 3'b000;
      unique case (op_in)
         3'b000: fs_in = 3'b000;
         3'b001: fs_in = 3'b001;
         3'b010: fs_in = 3'b010;
         3'b011: fs_in = 3'b011;
         3'b100: fs_in = 3'b100;
         3'b101: fs_in = 3'b000;
         3'b110: fs_in = FS_ZERO;
         3'b111: fs_in = FS_ZERO;
         default: fs_in = 3'b000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         da_q    <= '0;
         clr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         fs_q    <= '0;
         rw_q    <= 1'b0;
         done_q  <= 1'b0;
         icnt_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               rw_q <= 1'b0;
               if (bus.instr_valid) begin
                  op_q <= op_in;
                  da_q <= bus.instr[8:6];
                  if (op_in == OP_CLRALL) begin
                     // First clear write lands in the cycle right after acceptance.
                     state_q <= CLEAR;
                     clr_q   <= 3'd0;
                     d_q     <= 3'd0;
                     fs_q    <= FS_ZERO;
                     rw_q    <= 1'b1;
                  end else begin
                     state_q <= READ;
                     a_q     <= bus.instr[5:3];
                     b_q     <= bus.instr[2:0];
                     fs_q    <= fs_in;
                  end
               end
            end
            READ: begin
               if (op_q == OP_NOP) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  icnt_q  <= icnt_q + 8'd1;
               end else begin
                  state_q <= WRITE;
                  d_q     <= da_q;
                  rw_q    <= 1'b1;
               end
            end
            WRITE: begin
               state_q <= IDLE;
               rw_q    <= 1'b0;
               done_q  <= 1'b1;
               icnt_q  <= icnt_q + 8'd1;
            end
            CLEAR: begin
               if (clr_q == 3'd7) begin
                  state_q <= IDLE;
                  rw_q    <= 1'b0;
                  done_q  <= 1'b1;
                  icnt_q  <= icnt_q + 8'd1;
               end else begin
                  clr_q <= clr_q + 3'd1;
                  d_q   <= clr_q + 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               rw_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.instr_ready = (state_q == IDLE);
   assign bus.AAddress    = a_q;
   assign bus.BAddress    = b_q;
   assign bus.DAddress    = d_q;
   assign bus.ReadOrWrite = rw_q;
   assign bus.FS          = fs_q;
   assign bus.done        = done_q;
   assign bus.instr_count = icnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed testbench for datapath_sequencer.
// Drives instructions through the interface and checks cycle-exact outputs.
module tb_datapath_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   datapath_sequencer_if bus ();

   datapath_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr = '0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if (bus.instr_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", bus.instr_ready);
      else pass_cnt++;
      total_cnt++;
      if (bus.ReadOrWrite !== 1'b0) $display("FAIL rst_rw got %b exp 0", bus.ReadOrWrite);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL rst_done got %b exp 0", bus.done);
      else pass_cnt++;
      total_cnt++;
      if (bus.instr_count !== 8'd0) $display("FAIL rst_count got %0d exp 0", bus.instr_count);
      else pass_cnt++;
      total_cnt++;
      if ({bus.AAddress, bus.BAddress, bus.DAddress, bus.FS} !== 12'd0)
         $display("FAIL rst_addr got %h exp 000",
                  {bus.AAddress, bus.BAddress, bus.DAddress, bus.FS});
      else pass_cnt++;
   endtask

   task automatic test_add();
      do_reset();
      bus.instr_valid = 1'b1;
      bus.instr = 12'b001_011_001_010;
      step();
      bus.instr_valid = 1'b0;
      bus.instr = 12'hABC;
      total_cnt++;
      if ({bus.instr_ready, bus.AAddress, bus.BAddress, bus.FS, bus.ReadOrWrite} !== {1'b0, 3'd1, 3'd2, 3'b001, 1'b0})
         $display("FAIL add_read got rdy=%b a=%0d b=%0d fs=%b rw=%b exp 0 1 2 001 0",
                  bus.instr_ready, bus.AAddress, bus.BAddress, bus.FS, bus.ReadOrWrite);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.DAddress, bus.ReadOrWrite, bus.done, bus.FS} !== {3'd3, 1'b1, 1'b0, 3'b001})
         $display("FAIL add_write got d=%0d rw=%b done=%b fs=%b exp 3 1 0 001",
                  bus.DAddress, bus.ReadOrWrite, bus.done, bus.FS);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.done, bus.instr_count, bus.ReadOrWrite, bus.instr_ready} !== {1'b1, 8'd1, 1'b0, 1'b1})
         $display("FAIL add_done got done=%b cnt=%0d rw=%b rdy=%b exp 1 1 0 1",
                  bus.done, bus.instr_count, bus.ReadOrWrite, bus.instr_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL add_done_pulse got %b exp 0", bus.done);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int rw_pulses = 0;
      do_reset();
      bus.instr_valid = 1'b1;
      bus.instr = 12'b101_100_110_000;
      step();
      rw_pulses += int'(bus.ReadOrWrite);
      bus.instr = 12'b010_101_011_001;
      step();
      rw_pulses += int'(bus.ReadOrWrite);
      total_cnt++;
      if ({bus.DAddress, bus.ReadOrWrite, bus.FS, bus.AAddress} !== {3'd4, 1'b1, 3'b000, 3'd6})
         $display("FAIL b2b_mov_write got d=%0d rw=%b fs=%b a=%0d exp 4 1 000 6",
                  bus.DAddress, bus.ReadOrWrite, bus.FS, bus.AAddress);
      else pass_cnt++;
      step();
      rw_pulses += int'(bus.ReadOrWrite);
      total_cnt++;
      if ({bus.done, bus.instr_ready} !== 2'b11)
         $display("FAIL b2b_mov_done got done=%b rdy=%b exp 1 1", bus.done, bus.instr_ready);
      else pass_cnt++;
      step();
      rw_pulses += int'(bus.ReadOrWrite);
      bus.instr_valid = 1'b0;
      total_cnt++;
      if ({bus.instr_ready, bus.AAddress, bus.BAddress, bus.FS} !== {1'b0, 3'd3, 3'd1, 3'b010})
         $display("FAIL b2b_sub_read got rdy=%b a=%0d b=%0d fs=%b exp 0 3 1 010",
                  bus.instr_ready, bus.AAddress, bus.BAddress, bus.FS);
      else pass_cnt++;
      step();
      rw_pulses += int'(bus.ReadOrWrite);
      total_cnt++;
      if ({bus.DAddress, bus.ReadOrWrite} !== {3'd5, 1'b1})
         $display("FAIL b2b_sub_write got d=%0d rw=%b exp 5 1", bus.DAddress, bus.ReadOrWrite);
      else pass_cnt++;
      step();
      rw_pulses += int'(bus.ReadOrWrite);
      total_cnt++;
      if ({bus.done, bus.instr_count} !== {1'b1, 8'd2})
         $display("FAIL b2b_done got done=%b cnt=%0d exp 1 2", bus.done, bus.instr_count);
      else pass_cnt++;
      total_cnt++;
      if (rw_pulses != 2) $display("FAIL b2b_rw_pulses got %0d exp 2", rw_pulses);
      else pass_cnt++;
   endtask

   task automatic test_clrall();
      do_reset();
      bus.instr_valid = 1'b1;
      bus.instr = 12'b111_000_000_000;
      step();
      bus.instr_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         total_cnt++;
         if ({bus.ReadOrWrite, bus.DAddress, bus.FS, bus.instr_ready, bus.done} !== {1'b1, 3'(i), 3'b101, 1'b0, 1'b0})
            $display("FAIL clr_cycle%0d got rw=%b d=%0d fs=%b rdy=%b done=%b exp 1 %0d 101 0 0",
                     i, bus.ReadOrWrite, bus.DAddress, bus.FS, bus.instr_ready, bus.done, i);
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if ({bus.done, bus.ReadOrWrite, bus.instr_ready, bus.instr_count} !== {1'b1, 1'b0, 1'b1, 8'd1})
         $display("FAIL clr_done got done=%b rw=%b rdy=%b cnt=%0d exp 1 0 1 1",
                  bus.done, bus.ReadOrWrite, bus.instr_ready, bus.instr_count);
      else pass_cnt++;
   endtask

   task automatic test_nop();
      do_reset();
      bus.instr_valid = 1'b1;
      bus.instr = 12'b000_111_111_111;
      step();
      bus.instr_valid = 1'b0;
      total_cnt++;
      if ({bus.ReadOrWrite, bus.done, bus.instr_ready} !== 3'b000)
         $display("FAIL nop_read got rw=%b done=%b rdy=%b exp 0 0 0",
                  bus.ReadOrWrite, bus.done, bus.instr_ready);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.done, bus.ReadOrWrite, bus.instr_ready, bus.instr_count} !== {1'b1, 1'b0, 1'b1, 8'd1})
         $display("FAIL nop_done got done=%b rw=%b rdy=%b cnt=%0d exp 1 0 1 1",
                  bus.done, bus.ReadOrWrite, bus.instr_ready, bus.instr_count);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int late = 0;
      do_reset();
      bus.instr_valid = 1'b1;
      bus.instr = 12'b111_000_000_000;
      step();
      bus.instr_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      total_cnt++;
      if (bus.DAddress !== 3'd4) $display("FAIL abort_pre got d=%0d exp 4", bus.DAddress);
      else pass_cnt++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      total_cnt++;
      if ({bus.ReadOrWrite, bus.done, bus.instr_count, bus.instr_ready} !== {1'b0, 1'b0, 8'd0, 1'b1})
         $display("FAIL abort_rst got rw=%b done=%b cnt=%0d rdy=%b exp 0 0 0 1",
                  bus.ReadOrWrite, bus.done, bus.instr_count, bus.instr_ready);
      else pass_cnt++;
      for (int i = 0; i < 6; i++) begin
         step();
         late += int'(bus.ReadOrWrite) + int'(bus.done);
      end
      total_cnt++;
      if (late != 0) $display("FAIL abort_after got %0d rw/done pulses exp 0", late);
      else pass_cnt++;
      // reset beats a simultaneous acceptance
      rst = 1'b1;
      bus.instr_valid = 1'b1;
      bus.instr = 12'b111_000_000_000;
      step();
      rst = 1'b0;
      bus.instr_valid = 1'b0;
      total_cnt++;
      if ({bus.instr_ready, bus.ReadOrWrite} !== 2'b10)
         $display("FAIL rst_prio got rdy=%b rw=%b exp 1 0", bus.instr_ready, bus.ReadOrWrite);
      else pass_cnt++;
   endtask

   task automatic test_ignore();
      do_reset();
      bus.instr_valid = 1'b1;
      bus.instr = 12'b100_110_010_011;
      step();
      bus.instr = 12'b111_001_001_001;
      step();
      total_cnt++;
      if ({bus.DAddress, bus.ReadOrWrite, bus.FS, bus.AAddress, bus.BAddress} !== {3'd6, 1'b1, 3'b100, 3'd2, 3'd3})
         $display("FAIL ign_write got d=%0d rw=%b fs=%b a=%0d b=%0d exp 6 1 100 2 3",
                  bus.DAddress, bus.ReadOrWrite, bus.FS, bus.AAddress, bus.BAddress);
      else pass_cnt++;
      bus.instr_valid = 1'b0;
      step();
      total_cnt++;
      if ({bus.done, bus.instr_count} !== {1'b1, 8'd1})
         $display("FAIL ign_done got done=%b cnt=%0d exp 1 1", bus.done, bus.instr_count);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.ReadOrWrite, bus.instr_ready} !== 2'b01)
         $display("FAIL ign_idle got rw=%b rdy=%b exp 0 1", bus.ReadOrWrite, bus.instr_ready);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      int dones = 0;
      do_reset();
      bus.instr_valid = 1'b1;
      bus.instr = 12'b000_000_000_000;
      for (int k = 1; k <= 256; k++) begin
         step();
         step();
         dones += int'(bus.done);
         if (k == 255) begin
            total_cnt++;
            if (bus.instr_count !== 8'd255)
               $display("FAIL wrap_255 got %0d exp 255", bus.instr_count);
            else pass_cnt++;
         end
      end
      bus.instr_valid = 1'b0;
      total_cnt++;
      if (bus.instr_count !== 8'd0) $display("FAIL wrap_0 got %0d exp 0", bus.instr_count);
      else pass_cnt++;
      total_cnt++;
      if (dones != 256) $display("FAIL wrap_dones got %0d exp 256", dones);
      else pass_cnt++;
   endtask

   initial begin
      bus.instr_valid = 1'b0;
      bus.instr = '0;
      test_reset();
      test_add();
      test_back_to_back();
      test_clrall();
      test_nop();
      test_reset_abort();
      test_ignore();
      test_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
